// File: rtl/mxint_renormalizer.sv
// MxInt block renormalizer: narrows wide accumulator mantissas to OW bits using the
// smallest common right shift, folding that shift into the shared exponent.

module mxint_renorm_rsb #(
    parameter int IW = 16,
    parameter int SW = 5
) (
    input  logic [IW-1:0] m,
    output logic [SW-1:0] rsb
);
    logic run;

    // Count bits below the MSB that still match it; stops at the first differing bit.
    always_comb begin
        rsb = '0;
        run = 1'b1;
        for (int i = IW - 2; i >= 0; i--) begin
            if (run && (m[i] == m[IW-1])) rsb = rsb + SW'(1);
            else run = 1'b0;
        end
    end
endmodule

module mxint_renorm_shift #(
    parameter int IW = 16,
    parameter int OW = 8,
    parameter int SW = 5
) (
    input  logic [IW-1:0] m,
    input  logic [SW-1:0] sh,
    input  logic          sat,
    output logic [OW-1:0] q
);
    localparam logic signed [IW-1:0] QMAX = IW'(2 ** (OW - 1) - 1);
    localparam logic signed [IW-1:0] QMIN = ~QMAX;

    logic signed [IW-1:0] shifted;

    always_comb begin
        shifted = $signed(m) >>> sh;
        q = shifted[OW-1:0];
        if (sat) begin
            if (shifted > QMAX) q = QMAX[OW-1:0];
            else if (shifted < QMIN) q = QMIN[OW-1:0];
        end
    end
endmodule

module mxint_renormalizer #(
    parameter int DATA_IN_0_PRECISION_0  = 16,
    parameter int DATA_IN_0_PRECISION_1  = 4,
    parameter int BLOCK_SIZE             = 4,
    parameter int DATA_OUT_0_PRECISION_0 = 8,
    parameter int DATA_OUT_0_PRECISION_1 = DATA_IN_0_PRECISION_1
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [BLOCK_SIZE*DATA_IN_0_PRECISION_0-1:0]    mdata_in_0,
    input  logic [DATA_IN_0_PRECISION_1-1:0]               edata_in_0,
    input  logic                                           data_in_0_valid,
    output logic                                           data_in_0_ready,
    output logic [BLOCK_SIZE*DATA_OUT_0_PRECISION_0-1:0]   mdata_out_0,
    output logic [DATA_OUT_0_PRECISION_1-1:0]              edata_out_0,
    output logic                                           data_out_0_valid,
    input  logic                                           data_out_0_ready
);
    localparam int IW     = DATA_IN_0_PRECISION_0;
    localparam int EW     = DATA_IN_0_PRECISION_1;
    localparam int OW     = DATA_OUT_0_PRECISION_0;
    localparam int NL     = BLOCK_SIZE;
    localparam int SW     = $clog2(IW) + 1;
    localparam int XW     = ((EW > SW) ? EW : SW) + 1;
    localparam int EMAX   = 2 ** EW - 1;
    localparam int STAGES = 2;

    typedef struct packed {
        logic [NL-1:0][IW-1:0] mant;
        logic [EW-1:0]         exp;
        logic [SW-1:0]         shift;
    } s1_t;

    logic [STAGES:1]       vld_pipe;
    logic                  s1_load, s2_load;
    logic [NL-1:0][IW-1:0] m_in;
    logic [NL-1:0][SW-1:0] rsb;
    logic [SW-1:0]         rmin, s_raw;
    s1_t                   s1;

    logic [XW-1:0]         esum;
    logic                  ovf;
    logic [SW-1:0]         sh;
    logic [EW-1:0]         exp_next;
    logic [NL-1:0][OW-1:0] q;
    logic [NL-1:0][OW-1:0] m_out;
    logic [EW-1:0]         e_out;

    assign m_in    = mdata_in_0;
    assign s2_load = !vld_pipe[2] || data_out_0_ready;
    assign s1_load = !vld_pipe[1] || s2_load;

    assign data_in_0_ready  = s1_load;
    assign data_out_0_valid = vld_pipe[2];
    assign mdata_out_0      = m_out;
    assign edata_out_0      = e_out;

    for (genvar g = 0; g < NL; g++) begin : g_lane
        mxint_renorm_rsb #(.IW(IW), .SW(SW)) u_rsb (
            .m  (m_in[g]),
            .rsb(rsb[g])
        );
        mxint_renorm_shift #(.IW(IW), .OW(OW), .SW(SW)) u_shift (
            .m  (s1.mant[g]),
            .sh (sh),
            .sat(ovf),
            .q  (q[g])
        );
    end

    // Smallest shift that brings the least-redundant lane down to OW bits.
    always_comb begin
        rmin = rsb[0];
        for (int i = 1; i < NL; i++) begin
            if (rsb[i] < rmin) rmin = rsb[i];
        end
        s_raw = (rmin >= SW'(IW - OW)) ? '0 : (SW'(IW - OW) - rmin);
    end

    // On exponent overflow, shift only as far as the exponent can absorb and clamp.
    always_comb begin
        esum     = XW'(s1.exp) + XW'(s1.shift);
        ovf      = (esum > XW'(EMAX));
        sh       = ovf ? SW'(XW'(EMAX) - XW'(s1.exp)) : s1.shift;
        exp_next = ovf ? EW'(EMAX) : esum[EW-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            s1       <= '0;
            m_out    <= '0;
            e_out    <= '0;
        end else begin
            if (s1_load) vld_pipe[1] <= data_in_0_valid;
            if (s2_load) vld_pipe[2] <= vld_pipe[1];
            if (s1_load && data_in_0_valid) begin
                s1 <= '{mant: m_in, exp: edata_in_0, shift: s_raw};
            end
            if (s2_load && vld_pipe[1]) begin
                m_out <= q;
                e_out <= exp_next;
            end
        end
    end
endmodule
